// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data_mem port (m0 = CPU load/store, m1 = debug/loader).
// Fixed priority by default; define ROUND_ROBIN_EN for round-robin arbitration on ties.
module dmem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_ack_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_ack_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o,
  output logic          owner_o
);

  localparam int unsigned CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic          busy_q, busy_d;
  logic          grant_m1_c;
  logic          capture_c;

`ifdef ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // rr_q holds the last owner; on a tie the other requester wins.
  always_comb grant_m1_c = m1_req_i && (!m0_req_i || !rr_q);

  always_comb begin
    rr_d = rr_q;
    if (state_q == S_RESP) rr_d = owner_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end
`else
  always_comb grant_m1_c = m1_req_i && !m0_req_i;
`endif

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    capture_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          owner_d = grant_m1_c;
          we_d    = grant_m1_c ? m1_we_i    : m0_we_i;
          addr_d  = grant_m1_c ? m1_addr_i  : m0_addr_i;
          wdata_d = grant_m1_c ? m1_wdata_i : m0_wdata_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else if (RD_LATENCY == 0) begin
          capture_c = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d   = CW'(RD_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture_c = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture_c) begin
      if (owner_q) m1_rdata_d = mem_rdata_i;
      else         m0_rdata_d = mem_rdata_i;
    end

    mem_write_d = (state_d == S_ISSUE) && we_d;
    mem_read_d  = ((state_d == S_ISSUE) && !we_d) || (state_d == S_WAIT);
    mem_addr_d  = (mem_read_d || mem_write_d) ? addr_d : mem_addr_q;
    mem_wdata_d = mem_write_d ? wdata_d : mem_wdata_q;
    m0_ack_d    = (state_d == S_RESP) && !owner_d;
    m1_ack_d    = (state_d == S_RESP) && owner_d;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign m0_ack_o    = m0_ack_q;
  assign m1_ack_o    = m1_ack_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: three instances with read latency 1, 0 and 3,
// each attached to a small data_mem model.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m_req   [3][2];
  logic        m_we    [3][2];
  logic [31:0] m_addr  [3][2];
  logic [31:0] m_wdata [3][2];
  logic        m_ack   [3][2];
  logic [31:0] m_rdata [3][2];
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic        busy      [3];
  logic        owner     [3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int unsigned PI  = (LAT == 0) ? 0 : LAT - 1;
    logic [31:0] mem  [16];
    logic [31:0] pipe [3];

    dmem_port_arbiter #(.AW(32), .DW(32), .RD_LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req_i(m_req[g][0]), .m0_we_i(m_we[g][0]), .m0_addr_i(m_addr[g][0]),
      .m0_wdata_i(m_wdata[g][0]), .m0_ack_o(m_ack[g][0]), .m0_rdata_o(m_rdata[g][0]),
      .m1_req_i(m_req[g][1]), .m1_we_i(m_we[g][1]), .m1_addr_i(m_addr[g][1]),
      .m1_wdata_i(m_wdata[g][1]), .m1_ack_o(m_ack[g][1]), .m1_rdata_o(m_rdata[g][1]),
      .mem_read_o(mem_read[g]), .mem_write_o(mem_write[g]), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]),
      .busy_o(busy[g]), .owner_o(owner[g])
    );

    initial for (int i = 0; i < 16; i++) mem[i] = 32'hC000_0000 + 32'(g * 256) + 32'(i);

    // data_mem model: synchronous write, read data delayed by LAT cycles
    always @(posedge clk) begin
      if (mem_write[g]) mem[mem_addr[g][3:0]] <= mem_wdata[g];
      pipe[0] <= mem[mem_addr[g][3:0]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata[g] = (LAT == 0) ? mem[mem_addr[g][3:0]] : pipe[PI];
  end

  typedef struct {
    int          ch;
    int          m;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   errs   = 0;
  int   checks = 0;
  int   wr_cnt [3];
  int   rd_cnt [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input int m, input bit rd, input logic [31:0] d, input int c);
    exp_t e;
    e.ch = ch; e.m = m; e.rd = rd; e.data = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic start(input int ch, input int m, input bit we, input logic [31:0] a,
                       input logic [31:0] d);
    m_we[ch][m]    = we;
    m_addr[ch][m]  = a;
    m_wdata[ch][m] = d;
    m_req[ch][m]   = 1'b1;
  endtask

  // Wait for the ack of (ch,m); keep=1 leaves req high so the caller can chain a new access.
  task automatic finish(input int ch, input int m, input bit keep);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (m_ack[ch][m]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errs++;
      $display("FAIL timeout ch%0d m%0d: no ack within 40 cycles", ch, m);
    end
    if (!keep || !seen) m_req[ch][m] = 1'b0;
  endtask

  task automatic acc(input int ch, input int m, input bit we, input logic [31:0] a,
                     input logic [31:0] d);
    start(ch, m, we, a, d);
    finish(ch, m, 1'b0);
  endtask

  // Scoreboard monitor: every ack pops the next expected response.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 3; ch++) begin
        if (mem_write[ch]) wr_cnt[ch]++;
        if (mem_read[ch])  rd_cnt[ch]++;
        for (int m = 0; m < 2; m++) begin
          if (m_ack[ch][m]) begin
            checks++;
            if (sbq.size() == 0) begin
              errs++;
              $display("FAIL unexpected_ack: ch%0d m%0d acked with nothing pending (cycle %0d)",
                       ch, m, cyc);
            end else begin
              e = sbq.pop_front();
              if (e.ch != ch || e.m != m) begin
                errs++;
                $display("FAIL ack_order: got ch%0d m%0d expected ch%0d m%0d (cycle %0d)",
                         ch, m, e.ch, e.m, cyc);
              end else begin
                if (e.cyc >= 0) chk($sformatf("ack_cycle ch%0d m%0d", ch, m), 32'(cyc), 32'(e.cyc));
                if (e.rd) chk($sformatf("rdata ch%0d m%0d", ch, m), m_rdata[ch][m], e.data);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    int t;
    int fw;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wr_cnt[c] = 0;
      rd_cnt[c] = 0;
      for (int m = 0; m < 2; m++) begin
        m_req[c][m] = 1'b0; m_we[c][m] = 1'b0; m_addr[c][m] = '0; m_wdata[c][m] = '0;
      end
    end
    fork monitor(); join_none

    // T1: reset held with both requests pending
    start(0, 0, 1'b1, 32'd0, 32'h0000_0011);
    start(0, 1, 1'b1, 32'd1, 32'h0000_0022);
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_mem_read", 32'(mem_read[0]), 32'd0);
      chk("rst_mem_write", 32'(mem_write[0]), 32'd0);
      chk("rst_m0_ack", 32'(m_ack[0][0]), 32'd0);
      chk("rst_m1_ack", 32'(m_ack[0][1]), 32'd0);
    end
    chk("rst_m0_rdata", m_rdata[0][0], 32'd0);
    chk("rst_m1_rdata", m_rdata[0][1], 32'd0);
`ifdef ROUND_ROBIN_EN
    fw = 1;
`else
    fw = 0;
`endif
    t = cyc;
    push(0, fw, 1'b0, 32'd0, t + 2);
    push(0, 1 - fw, 1'b0, 32'd0, t + 5);
    rst_n = 1'b1;
    fork
      finish(0, 0, 1'b0);
      finish(0, 1, 1'b0);
    join
    chk("t1_mem0", g_ch[0].mem[0], 32'h0000_0011);
    chk("t1_mem1", g_ch[0].mem[1], 32'h0000_0022);

    // T2: m0 write
    @(negedge clk);
    wr_cnt[0] = 0;
    push(0, 0, 1'b0, 32'd0, cyc + 2);
    acc(0, 0, 1'b1, 32'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_write_cycles", 32'(wr_cnt[0]), 32'd1);
    chk("t2_mem2", g_ch[0].mem[2], 32'hDEAD_BEEF);

    // T3: m1 read back
    rd_cnt[0] = 0;
    push(0, 1, 1'b1, 32'hDEAD_BEEF, cyc + 3);
    acc(0, 1, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
    chk("t3_read_cycles", 32'(rd_cnt[0]), 32'd2);
    chk("t3_m0_rdata_held", m_rdata[0][0], 32'd0);

    // T5: reset during WAIT abandons the read
    start(0, 0, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
    chk("t5_issue_read", 32'(mem_read[0]), 32'd1);
    @(negedge clk);
    chk("t5_wait_read", 32'(mem_read[0]), 32'd1);
    chk("t5_wait_busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_read", 32'(mem_read[0]), 32'd0);
    chk("t5_rst_busy", 32'(busy[0]), 32'd0);
    chk("t5_rst_addr", mem_addr[0], 32'd0);
    m_req[0][0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(0, 0, 1'b1, 32'hDEAD_BEEF, cyc + 3);
    acc(0, 0, 1'b0, 32'd2, 32'd0);

    // T4: four accesses from each requester, both requesting together
    @(negedge clk);
`ifdef ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 1'b1, 32'hC000_000C + 32'(i), -1);
      push(0, 0, 1'b0, 32'd0, -1);
    end
`else
    for (int i = 0; i < 4; i++) push(0, 0, 1'b0, 32'd0, -1);
    for (int i = 0; i < 4; i++) push(0, 1, 1'b1, 32'hC000_000C + 32'(i), -1);
`endif
    fork
      for (int i = 0; i < 4; i++) begin
        start(0, 0, 1'b1, 32'd4 + 32'(i), 32'h0000_00A0 + 32'(i));
        finish(0, 0, i < 3);
      end
      for (int j = 0; j < 4; j++) begin
        start(0, 1, 1'b0, 32'd12 + 32'(j), 32'd0);
        finish(0, 1, j < 3);
      end
    join
    chk("t4_mem4", g_ch[0].mem[4], 32'h0000_00A0);
    chk("t4_mem7", g_ch[0].mem[7], 32'h0000_00A3);

    // T6: read latency 0 and 3
    @(negedge clk);
    push(1, 1, 1'b1, 32'hC000_0105, cyc + 2);
    acc(1, 1, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    push(2, 0, 1'b1, 32'hC000_0207, cyc + 5);
    acc(2, 0, 1'b0, 32'd7, 32'd0);
    @(negedge clk);
    push(2, 1, 1'b0, 32'd0, cyc + 2);
    acc(2, 1, 1'b1, 32'd9, 32'h1234_5678);
    @(negedge clk);
    push(2, 1, 1'b1, 32'h1234_5678, cyc + 5);
    acc(2, 1, 1'b0, 32'd9, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
